// File: rtl/lsu_pkg.sv
// lsu_pkg: memory-op encodings, stage states, lane strobes and op classification helpers.
package lsu_pkg;
    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_LB   = 4'b0001;
    localparam logic [3:0] OP_LH   = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0011;
    localparam logic [3:0] OP_LBU  = 4'b0100;
    localparam logic [3:0] OP_LHU  = 4'b0101;
    localparam logic [3:0] OP_SB   = 4'b1001;
    localparam logic [3:0] OP_SH   = 4'b1010;
    localparam logic [3:0] OP_SW   = 4'b1011;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_e;

    function automatic logic is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Unrecognised codes collapse to NONE so the rest of the stage sees only legal ops.
    function automatic logic [3:0] norm_op(input logic [3:0] op);
        return (is_load(op) || is_store(op)) ? op : OP_NONE;
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        return ((op == OP_LH || op == OP_LHU || op == OP_SH) && a[0]) ||
               ((op == OP_LW || op == OP_SW) && a != 2'b00);
    endfunction
endpackage

// File: rtl/load_extract.sv
// load_extract: selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [3:0]  op,
    output logic [31:0] value
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{addr, 3'b000} +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        value = op == OP_LB  ? {{24{b[7]}}, b} :
                op == OP_LBU ? {24'b0, b} :
                op == OP_LH  ? {{16{h[15]}}, h} :
                op == OP_LHU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: load/store stage issuing at most one memory transaction per instruction
// and presenting extended write-back data over a valid/ready handshake.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] store_data,
    input  logic [3:0]       mem_op,
    input  logic [4:0]       rd_addr,
    input  logic             rd_wen,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_wen,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [4:0]       wb_rd,
    output logic             wb_wen,
    output logic             misalign
);
    state_e           state, state_d;
    logic [3:0]       op_q, op_in;
    logic [WIDTH-1:0] addr_q, sdata_q, wb_data_q, ld_val;
    logic [4:0]       rd_q;
    logic             rd_wen_q, mis_q, in_ready_q, mis_in, req, st;

    assign op_in  = norm_op(mem_op);
    assign mis_in = misaligned(op_in, alu_result[1:0]);

    load_extract u_extract (
        .rdata (mem_rdata),
        .addr  (addr_q[1:0]),
        .op    (op_q),
        .value (ld_val)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (in_valid) state_d = (op_in == OP_NONE || mis_in) ? OUT : REQ;
            REQ:  if (mem_req_ready) state_d = is_store(op_q) ? OUT : RESP;
            RESP: if (mem_rvalid) state_d = OUT;
            OUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is registered from the next state so it never follows out_ready combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            op_q       <= OP_NONE;
            addr_q     <= '0;
            sdata_q    <= '0;
            wb_data_q  <= '0;
            rd_q       <= '0;
            rd_wen_q   <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state      <= state_d;
            in_ready_q <= state_d == IDLE;
            if (state == IDLE && in_valid) begin
                op_q      <= op_in;
                addr_q    <= alu_result;
                sdata_q   <= store_data;
                wb_data_q <= alu_result;
                rd_q      <= rd_addr;
                rd_wen_q  <= rd_wen;
                mis_q     <= mis_in;
            end
            if (state == RESP && mem_rvalid) wb_data_q <= ld_val;
        end
    end

    assign req           = state == REQ;
    assign st            = is_store(op_q);
    assign in_ready      = in_ready_q;
    assign mem_req_valid = req;
    assign mem_addr      = req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    assign mem_wen       = req && st;
    assign mem_wstrb     = !(req && st) ? 4'b0000 :
                           op_q == OP_SB ? STRB_B << addr_q[1:0] :
                           op_q == OP_SH ? STRB_H << addr_q[1:0] : STRB_W;
    assign mem_wdata     = !(req && st) ? '0 :
                           op_q == OP_SB ? {4{sdata_q[7:0]}} :
                           op_q == OP_SH ? {2{sdata_q[15:0]}} : sdata_q;
    assign out_valid     = state == OUT;
    assign wb_data       = wb_data_q;
    assign wb_rd         = rd_q;
    assign wb_wen        = rd_wen_q && rd_q != 5'd0 && !st && !mis_q;
    assign misalign      = mis_q;
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed and randomized transactions checked against a behavioural model.
module tb_lsu_stage;
    logic        clk = 1'b0, rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] alu_result = '0, store_data = '0;
    logic [3:0]  mem_op = '0;
    logic [4:0]  rd_addr = '0;
    logic        rd_wen = 1'b0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid = 1'b0, out_valid, out_ready = 1'b0;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wen, misalign;
    int          errors = 0, checks = 0;

    lsu_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data), .mem_op(mem_op),
        .rd_addr(rd_addr), .rd_wen(rd_wen), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_wen(wb_wen), .misalign(misalign)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_load(input logic [3:0] op);
        return op == 1 || op == 2 || op == 3 || op == 4 || op == 5;
    endfunction

    function automatic bit m_store(input logic [3:0] op);
        return op == 9 || op == 10 || op == 11;
    endfunction

    function automatic bit m_mis(input logic [3:0] op, input logic [31:0] a);
        int sz;
        sz = (op == 2 || op == 5 || op == 10) ? 2 : (op == 3 || op == 11) ? 4 : 1;
        return (m_load(op) || m_store(op)) && (a % sz) != 0;
    endfunction

    function automatic logic [31:0] m_load_val(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        h = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (op)
            1: return b >= 128 ? b - 256 : b;
            4: return b;
            2: return h >= 32768 ? h - 65536 : h;
            5: return h;
            default: return rd;
        endcase
    endfunction

    task automatic run_txn(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] rd, input bit rw, input logic [31:0] rdata,
                           input int req_dly, input int out_dly);
        int n;
        bit ld, st, m, none;
        logic [31:0] e_strb, e_wdata, e_wb;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            return;
        end
        ld = m_load(op); st = m_store(op); none = !ld && !st; m = m_mis(op, alu);
        in_valid = 1; mem_op = op; alu_result = alu; store_data = sd; rd_addr = rd; rd_wen = rw;
        @(posedge clk); #1;
        in_valid = 0; alu_result = $urandom; store_data = $urandom; mem_op = 4'($urandom);
        rd_addr = 5'($urandom); rd_wen = 1'($urandom);
        if (none || m) begin
            check("no_req", mem_req_valid, 0);
        end else begin
            e_strb = op == 9 ? 1 << (alu % 4) : op == 10 ? 3 << (alu % 4) : op == 11 ? 15 : 0;
            e_wdata = op == 9 ? (sd & 32'hFF) * 32'h01010101 :
                      op == 10 ? (sd & 32'hFFFF) * 32'h00010001 : sd;
            for (int i = 0; i <= req_dly; i++) begin
                check("req_valid", mem_req_valid, 1);
                check("req_addr", mem_addr, alu - (alu % 4));
                check("req_wen", mem_wen, st);
                check("req_wstrb", mem_wstrb, e_strb);
                if (st) check("req_wdata", mem_wdata, e_wdata);
                check("req_no_out", out_valid, 0);
                if (i == req_dly) mem_req_ready = 1;
                @(posedge clk); #1;
            end
            mem_req_ready = 0;
            if (ld) begin
                check("resp_no_req", mem_req_valid, 0);
                check("resp_no_out", out_valid, 0);
                mem_rvalid = 1; mem_rdata = rdata;
                @(posedge clk); #1;
                mem_rvalid = 0; mem_rdata = $urandom;
            end
        end
        e_wb = none ? alu : m_load_val(op, alu, rdata);
        for (int i = 0; i <= out_dly; i++) begin
            check("out_valid", out_valid, 1);
            check("out_in_ready", in_ready, 0);
            check("wb_rd", wb_rd, rd);
            check("wb_wen", wb_wen, rw && rd != 0 && !st && !m);
            check("misalign", misalign, m);
            if (!st && !m) check("wb_data", wb_data, e_wb);
            if (i == out_dly) out_ready = 1;
            @(posedge clk); #1;
        end
        out_ready = 0;
        check("done_out_valid", out_valid, 0);
        check("done_in_ready", in_ready, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_req_valid"}, mem_req_valid, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wen"}, mem_wen, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_wstrb"}, mem_wstrb, 0);
        check({tag, "_wb_data"}, wb_data, 0);
        check({tag, "_wb_rd"}, wb_rd, 0);
        check({tag, "_wb_wen"}, wb_wen, 0);
        check({tag, "_misalign"}, misalign, 0);
    endtask

    logic [3:0] ops [11] = '{0, 1, 2, 3, 4, 5, 9, 10, 11, 6, 15};

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        check("post_reset_in_ready", in_ready, 1);

        run_txn(4'b0000, 32'h1234_5678, 32'h0, 5'd5, 1, 32'h0, 0, 0);
        run_txn(4'b0001, 32'h0000_1003, 32'h0, 5'd7, 1, 32'h80FF_7F01, 0, 0);
        run_txn(4'b0100, 32'h0000_1003, 32'h0, 5'd7, 1, 32'h80FF_7F01, 0, 0);
        run_txn(4'b1010, 32'h0000_2002, 32'hAAAA_BEEF, 5'd3, 1, 32'h0, 3, 0);
        run_txn(4'b0011, 32'h0000_3001, 32'h0, 5'd9, 1, 32'h0, 0, 0);
        run_txn(4'b0010, 32'h0000_4002, 32'h0, 5'd10, 1, 32'h8001_7FFF, 0, 4);

        // Reset while the load is waiting for its response.
        in_valid = 1; mem_op = 4'b0011; alu_result = 32'h0000_5000; rd_addr = 5'd4; rd_wen = 1;
        @(posedge clk); #1;
        in_valid = 0;
        mem_req_ready = 1;
        @(posedge clk); #1;
        mem_req_ready = 0;
        rst = 0;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rvalid = 0;
        check("late_rvalid_out", out_valid, 0);
        check("late_rvalid_in_ready", in_ready, 1);
        check("late_rvalid_req", mem_req_valid, 0);
        check("late_rvalid_wb", wb_data, 0);

        for (int k = 0; k < 60; k++) begin
            logic [4:0] rd;
            rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
            run_txn(ops[$urandom_range(0, 10)], $urandom, $urandom, rd, 1'($urandom),
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_stage.md
# lsu_stage

Load/store stage directly downstream of the execute unit. It consumes the ALU result, which is either a memory address or a pass-through value, together with the store operand and destination register. It performs at most one memory transaction per instruction over a valid/ready request bus with a separate read-response strobe. It then presents aligned, sign- or zero-extended write-back data to the register-file write stage through a valid/ready output handshake.

## Interface
- WIDTH, 32, datapath width; only 32 is supported (4 byte lanes).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; high only in IDLE.
- alu_result  in  WIDTH  address for memory ops, write-back value otherwise.
- store_data  in  WIDTH  rs2 value for stores.
- mem_op  in  4  0000 NONE, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1001 SB, 1010 SH, 1011 SW; any other code is treated as NONE.
- rd_addr  in  5  destination register.
- rd_wen  in  1  instruction writes rd.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  WIDTH  word-aligned address ({alu_result[31:2],2'b00}).
- mem_wen  out  1  1 = store, 0 = load.
- mem_wdata  out  WIDTH  store data shifted into lane position.
- mem_wstrb  out  4  byte strobes (0 for loads).
- mem_rvalid  in  1  read response valid (single cycle).
- mem_rdata  in  WIDTH  read response word.
- out_valid  out  1  write-back result valid.
- out_ready  in  1  write-back stage accepts.
- wb_data  out  WIDTH  result value.
- wb_rd  out  5  destination register.
- wb_wen  out  1  register write enable.
- misalign  out  1  access was misaligned and was suppressed.

## Operation
- FSM states: IDLE, REQ, RESP, OUT.
- IDLE:
  - On in_valid, capture all inputs.
  - NONE goes to OUT with wb_data = alu_result.
  - A misaligned access goes to OUT with misalign = 1, wb_wen = 0, and no memory request. Halfword is misaligned if addr[0] = 1; word is misaligned if addr[1:0] ≠ 0.
  - Any other access goes to REQ.
- REQ:
  - mem_req_valid = 1. Address, data, strobe and wen stay stable until mem_req_ready.
  - Store handshake goes to OUT with wb_wen = 0.
  - Load handshake goes to RESP.
- RESP: wait for mem_rvalid. Extract the lane selected by addr[1:0], sign- or zero-extend it, latch it into wb_data, then go to OUT.
- OUT: out_valid = 1 and all wb_* outputs are held until out_ready, then return to IDLE.
- wb_wen = rd_wen && rd_addr ≠ 0 && (op is NONE or load) && !misalign.
- Strobes:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << addr[1:0].
  - SW: 4'b1111.
- Store data lane placement: SB replicates byte [7:0] to all lanes; SH replicates halfword [15:0] to both halves.
- mem_rvalid outside RESP is ignored.

## Timing
- Reset values: in_ready = 0 while rst is low, and 1 in IDLE after release. All other outputs are 0. State is IDLE.
- Reset mid-operation: the in-flight instruction is dropped, and a late mem_rvalid is ignored.
- Latencies, with accept at cycle 0:
  - NONE or misaligned: out_valid at cycle 1.
  - Store with mem_req_ready already high: request at cycle 1, out_valid at cycle 2.
  - Load with immediate ready and rvalid one cycle after the handshake: out_valid at cycle 3.
- Back-to-back throughput: accepting the next instruction in the cycle after OUT completes, so at most one instruction per 2 cycles.
- in_ready is a registered state decode, with no combinational path from out_ready.
- mem_req_valid never drops before mem_req_ready.

## Structure
- Package lsu_pkg holds:
  - the mem_op encodings as localparams;
  - the state enum;
  - the lane-strobe constants.
- One combinational sub-module, load_extract. It takes rdata, addr[1:0] and op, and produces the extended 32-bit value.
- The FSM, capture registers and store lane shifting are in lsu_stage.

## Test plan
- NONE, alu_result = 0x1234_5678, rd = 5, rd_wen = 1, out_ready = 1 → out_valid at cycle 1, wb_data = 0x1234_5678, wb_wen = 1, no mem_req_valid.
- LB at addr 0x1003, rdata 0x80FF_7F01 → mem_addr 0x1000, wb_data 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at addr 0x2002 with store_data 0xAAAA_BEEF and mem_req_ready held low for 3 cycles → request fields stable throughout, mem_wstrb 4'b1100, mem_wdata 0xBEEF_BEEF, wb_wen = 0.
- LW at addr 0x3001 → misalign = 1, wb_wen = 0, mem_req_valid never asserted.
- Load in RESP with rst pulsed low → all outputs 0. A mem_rvalid one cycle after release is ignored; in_ready = 1 and out_valid = 0.
- out_ready held low for 4 cycles after a load → out_valid and wb_data stable, in_ready = 0. The next instruction is accepted the cycle after out_ready rises.
